// File: rtl/uart_wb_tracer.sv
// Write-back trace tap: buffers register write-back events in a FIFO and
// streams each one out as a 3-byte 8N1 UART frame ({A,dest}, data hi, data lo).
module uart_wb_tracer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PTR_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dest,
  input  logic [15:0] wb_data,
  input  logic        clr_overflow,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH   = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
  } trace_ent_t;

  trace_ent_t [FIFO_DEPTH-1:0] mem_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  trace_ent_t       ent_q, ent_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic       full, push, drop, pop, tick;
  logic [7:0] cur_byte;

  // Space is judged on the registered count only, so a same-edge pop never
  // lets a push into a full FIFO.
  assign full = (cnt_q == DEPTH);
  assign push = wb_valid && !full;
  assign drop = wb_valid && full;
  assign tick = (bitcnt_q == CNT_MAX);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    ent_d      = ent_q;
    fcnt_d     = fcnt_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bitcnt_d = '0;
        if (cnt_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        ent_d      = mem_q[rd_ptr_q];
        pop        = 1'b1;
        byte_idx_d = 2'd0;
        bitcnt_d   = '0;
        state_d    = S_START;
      end
      S_START: begin
        if (tick) begin
          bitcnt_d  = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          bitcnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          bitcnt_d = '0;
          // Bytes of one frame run back to back; only the frame end returns to IDLE.
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end else begin
            fcnt_d  = fcnt_q + 16'd1;
            state_d = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = {4'hA, ent_q.dest};
      2'd1:    cur_byte = ent_q.data[15:8];
      default: cur_byte = ent_q.data[7:0];
    endcase
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_byte[bit_idx_q];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      ent_q      <= '0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      ent_q      <= ent_d;
      ovf_q      <= ovf_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= '{dest: wb_dest, data: wb_data};
  end

  assign busy        = (cnt_q != '0) || (state_q != S_IDLE);
  assign fifo_full   = full;
  assign overflow    = ovf_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_uart_wb_tracer.sv
// Randomized + directed bench for uart_wb_tracer against a queue/timer model
// that predicts tx from frame-relative time each cycle.
module tb_uart_wb_tracer;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 30 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbv = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  dest = '0;
  logic [15:0] data = '0;
  logic        tx, busy, full, ovf;
  logic [15:0] fc;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [19:0] mq[$];
  int          ph = 0;   // 0 idle, 1 load, 2 sending
  int          rem = 0;  // clocks left in the current frame
  logic [19:0] cur = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_fc = '0;

  logic tr [0:511];
  int   ecnt = 0;

  uart_wb_tracer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .reset(rst_n), .wb_valid(wbv), .wb_dest(dest), .wb_data(data),
    .clr_overflow(clr), .tx(tx), .busy(busy), .fifo_full(full),
    .overflow(ovf), .frame_count(fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_edge();
    int  pre;
    bit  psh, drp;
    if (!rst_n) begin
      mq.delete(); ph = 0; rem = 0; m_ovf = 1'b0; m_fc = '0;
      return;
    end
    pre = mq.size();
    psh = wbv && (pre < DEPTH);
    drp = wbv && !psh;
    case (ph)
      0: if (pre > 0) ph = 1;
      1: begin cur = mq.pop_front(); ph = 2; rem = FRAME; end
      default: begin
        rem--;
        if (rem == 0) begin ph = 0; m_fc++; end
      end
    endcase
    if (psh) mq.push_back({dest, data});
    if (drp) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  function automatic logic exp_tx();
    int e, pos, w;
    logic [7:0] b;
    if (ph != 2) return 1'b1;
    e   = FRAME - rem;
    pos = e / CPB;
    w   = pos % 10;
    case (pos / 10)
      0:       b = {4'hA, cur[19:16]};
      1:       b = cur[15:8];
      default: b = cur[7:0];
    endcase
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return b[w-1];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tx", tx, exp_tx());
    chk("busy", busy, (mq.size() > 0 || ph != 0));
    chk("full", full, (mq.size() == DEPTH));
    chk("ovf", ovf, m_ovf);
    chk("fcnt", fc, m_fc);
    if (ecnt < 512) tr[ecnt] = tx;
    ecnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wbv = 1'b0; clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int i;
    wbv = 1'b0; clr = 1'b0;
    for (i = 0; i < bound; i++) begin
      if (ph == 0 && mq.size() == 0) break;
      step();
    end
    if (!(ph == 0 && mq.size() == 0)) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles", bound);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int base, input int b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tr[base + (b*10 + 1 + i)*CPB + 1];
    return r;
  endfunction

  task automatic push1(input logic [3:0] d, input logic [15:0] v);
    wbv = 1'b1; dest = d; data = v;
    step();
    wbv = 1'b0;
  endtask

  initial begin
    int run, k;
    // reset state
    do_reset();
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0); chk("rst_fc", fc, 0);

    // single frame, latency and byte content
    ecnt = 0;
    push1(4'h3, 16'h1234);
    step();
    chk("t1_tx_e1", tr[1], 1);
    for (k = 2; k <= 122; k++) step();
    chk("t1_tx_e2", tr[2], 0);
    chk("t1_b0", rx_byte(2, 0), 8'hA3);
    chk("t1_b1", rx_byte(2, 1), 8'h12);
    chk("t1_b2", rx_byte(2, 2), 8'h34);
    chk("t1_stop_e121", tr[121], 1);
    chk("t1_fc", fc, 1);
    chk("t1_busy", busy, 0);

    // ten back-to-back events, 10th dropped
    do_reset();
    for (k = 0; k < 10; k++) begin
      wbv = 1'b1; dest = 4'($urandom); data = 16'($urandom);
      step();
      if (k == 8) begin chk("t2_full_e8", full, 1); chk("t2_ovf_e8", ovf, 0); end
    end
    chk("t2_full_e9", full, 1);
    chk("t2_ovf_e9", ovf, 1);
    drain(1400);
    chk("t2_fc", fc, 9);

    // set beats clear; lone clear then clears
    do_reset();
    for (k = 0; k < 10; k++) begin wbv = 1'b1; data = 16'($urandom); step(); end
    wbv = 1'b1; clr = 1'b1; step();
    chk("t3_set_wins", ovf, 1);
    wbv = 1'b0; clr = 1'b1; step();
    clr = 1'b0;
    chk("t3_clear", ovf, 0);
    drain(1400);

    // extreme bytes and inter-frame gap
    do_reset();
    ecnt = 0;
    wbv = 1'b1; dest = 4'hF; data = 16'hFFFF; step();
    dest = 4'h0; data = 16'h0000; step();
    wbv = 1'b0;
    while (ecnt < 250) step();
    chk("t4_f1b0", rx_byte(2, 0), 8'hAF);
    chk("t4_f1b1", rx_byte(2, 1), 8'hFF);
    chk("t4_f1b2", rx_byte(2, 2), 8'hFF);
    chk("t4_f2b0", rx_byte(124, 0), 8'hA0);
    chk("t4_f2b1", rx_byte(124, 1), 8'h00);
    chk("t4_f2b2", rx_byte(124, 2), 8'h00);
    run = 0;
    for (k = 118; k < 200 && tr[k] === 1'b1; k++) run++;
    chk("t4_gap", run, 6);
    drain(400);

    // reset mid-frame during byte1 data, then a clean restart
    do_reset();
    push1(4'h5, 16'hA5C3);
    for (k = 0; k < 51; k++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_tx", tx, 1); chk("t5_busy", busy, 0);
    chk("t5_full", full, 0); chk("t5_fc", fc, 0);
    ecnt = 0;
    push1(4'h9, 16'h0F0F);
    step(); step();
    chk("t5_restart_e1", tr[1], 1);
    chk("t5_restart_e2", tr[2], 0);
    drain(400);

    // push on the LOAD edge with three entries queued
    do_reset();
    push1(4'h1, 16'h1111);
    for (k = 0; k < 20; k++) step();
    push1(4'h2, 16'h2222); push1(4'h3, 16'h3333); push1(4'h4, 16'h4444);
    for (k = 0; k < 400 && ph != 1; k++) step();
    wbv = 1'b1; dest = 4'h5; data = 16'h5555; step(); wbv = 1'b0;
    chk("t6_notfull", full, 0);
    drain(1000);
    chk("t6_fc", fc, 5);

    // randomized traffic with bursts, clears and rare resets
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      int p;
      p     = ((i / 500) % 3 == 0) ? 60 : 4;
      wbv   = ($urandom_range(0, 99) < p);
      dest  = 4'($urandom);
      data  = 16'($urandom);
      clr   = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1;
    drain(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_wb_tracer.md
Name: uart_wb_tracer

Overview:
Downstream consumer of the pipeline's write-back stage: captures every register write-back event (RegWriteW, destAddW, ResultW) into a small FIFO. Serializes each event as a 3-byte 8N1 UART frame on a single TX pin, giving an external host a live trace of architectural register updates. Exports FIFO-full to the hazard unit, which may use it to stall the pipeline.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; integer >= 2.
FIFO_DEPTH, 8, trace entries buffered; power of 2.
PTR_W, 3, log2(FIFO_DEPTH).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
wb_valid  in  1  write-back event this cycle (driven from RegWriteW).
wb_dest  in  4  destination register (destAddW).
wb_data  in  16  written value (ResultW).
clr_overflow  in  1  one-cycle pulse clearing overflow.
tx  out  1  UART serial output, idle high.
busy  out  1  FIFO non-empty or TX FSM not IDLE.
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
overflow  out  1  sticky: an event was dropped.
frame_count  out  16  completed frames, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (reset==0 at a rising edge): tx=1, busy=0, fifo_full=0, overflow=0, frame_count=0; FIFO pointers/count cleared; FSM=IDLE. Mid-frame reset abandons the frame; tx is high after that edge.
- FIFO entry = {wb_dest, wb_data}, 20 bits. Push when wb_valid==1 and count<FIFO_DEPTH, evaluated on the registered count before this edge.
- A pop in the same cycle does not free space for a push: when full, wb_valid is dropped even if LOAD pops that edge.
- Drop sets overflow=1. If clr_overflow and a drop occur in the same cycle, overflow stays 1 (set wins).
- fifo_full = (count==FIFO_DEPTH), registered-count based. Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx=1. FIFO non-empty -> LOAD.
  - LOAD: latch head entry, pop, byte_idx=0 -> START.
  - START: tx=0 for CLKS_PER_BIT clocks -> DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT clocks each -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks. If byte_idx<2: byte_idx+1 -> START, no gap. Else frame_count+1 -> IDLE.
- Frame bytes: byte0={4'hA, dest}, byte1=data[15:8], byte2=data[7:0].
- Latency: push at edge N into an idle, empty block -> LOAD after edge N+1 -> tx falls after edge N+2.
- One frame = 30*CLKS_PER_BIT clocks. Between back-to-back frames, tx stays high for CLKS_PER_BIT+2 clocks: stop bit, then IDLE, then LOAD.
- Bit timing uses a counter 0..CLKS_PER_BIT-1, reset on every state entry.
- The latched entry is unaffected by later pushes.

Test Plan:
1. CLKS_PER_BIT=4; one push dest=3, data=0x1234 at edge 0 -> tx low from edge 2; bytes 0xA3,0x12,0x34 LSB-first; tx high again at edge 122; frame_count=1; busy=0 after edge 122.
2. Ten consecutive wb_valid cycles (edges 0-9) from idle, FIFO_DEPTH=8 -> pop at edge 2; count reaches 8 after edge 8; 10th event dropped; overflow=1, fifo_full=1 after edge 9; exactly 9 frames emitted; frame_count=9.
3. FIFO full, wb_valid=1 and clr_overflow=1 in the same cycle -> overflow remains 1. A later lone clr_overflow -> overflow=0.
4. Two pushes (dest=F, data=0xFFFF; dest=0, data=0x0000) -> frames 0xAF,0xFF,0xFF then 0xA0,0x00,0x00; inter-frame high gap = 6 clocks after the stop bit starts (4 stop + 2).
5. reset=0 during byte1 data bits -> after that edge: tx=1, busy=0, fifo_full=0, frame_count=0. Next push restarts a clean frame 2 clocks later.
6. Push on the same edge LOAD pops, with count=3 -> count stays 3; entry order preserved in the output bytes.
